// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector: host loads pattern/length/overlap/threshold,
// arms detection on a qualified bit stream, counts matches and halts at threshold.
module seq_detect_ctrl #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic             start,
  input  logic             stop,
  input  logic             i_valid,
  input  logic             i,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic [PAT_W-1:0] pattern_r;
  logic [LEN_W-1:0] len_r;
  logic             overlap_r;
  logic [CNT_W-1:0] thresh_r;
  logic [PAT_W-1:0] history_r;
  logic [LEN_W-1:0] fill_r;
  logic             out_r;
  logic [CNT_W-1:0] match_count_r;

  logic [LEN_W-1:0] len_clamp_s;
  logic [PAT_W-1:0] hist_next_s;
  logic [PAT_W-1:0] mask_s;
  logic [LEN_W:0]   fill_inc_s;
  logic [LEN_W-1:0] fill_sat_s;
  logic             hit_s;
  logic [CNT_W-1:0] cnt_inc_s;

  // Next-value datapath: clamped length, shifted history, match test, saturating count.
  always_comb begin
    len_clamp_s = cfg_len;
    if (cfg_len == {LEN_W{1'b0}}) begin
      len_clamp_s = LEN_ONE;
    end else if (cfg_len > LEN_MAX) begin
      len_clamp_s = LEN_MAX;
    end else begin
      len_clamp_s = cfg_len;
    end
    hist_next_s = {history_r[PAT_W-2:0], i};
    mask_s      = {PAT_W{1'b0}};
    for (int k = 0; k < PAT_W; k++) begin
      mask_s[k] = (k < int'(len_r));
    end
    fill_inc_s = {1'b0, fill_r} + {{LEN_W{1'b0}}, 1'b1};
    if (fill_inc_s >= {1'b0, len_r}) begin
      fill_sat_s = len_r;
    end else begin
      fill_sat_s = fill_inc_s[LEN_W-1:0];
    end
    // The match is judged on the post-shift history, qualified by how many bits have filled.
    hit_s = (fill_inc_s >= {1'b0, len_r}) &&
            (((hist_next_s ^ pattern_r) & mask_s) == {PAT_W{1'b0}});
    if (match_count_r == CNT_MAX) begin
      cnt_inc_s = CNT_MAX;
    end else begin
      cnt_inc_s = match_count_r + CNT_ONE;
    end
  end

  // Control state, configuration capture and detection datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      pattern_r     <= {PAT_W{1'b0}};
      len_r         <= LEN_ONE;
      overlap_r     <= 1'b0;
      thresh_r      <= {CNT_W{1'b0}};
      history_r     <= {PAT_W{1'b0}};
      fill_r        <= {LEN_W{1'b0}};
      out_r         <= 1'b0;
      match_count_r <= {CNT_W{1'b0}};
    end else begin
      out_r <= 1'b0;
      if ((state_r == ST_IDLE) && cfg_valid) begin
        pattern_r <= cfg_pattern;
        len_r     <= len_clamp_s;
        overlap_r <= cfg_overlap;
        thresh_r  <= cfg_thresh;
      end
      if (stop) begin
        state_r   <= ST_IDLE;
        history_r <= {PAT_W{1'b0}};
        fill_r    <= {LEN_W{1'b0}};
      end else begin
        case (state_r)
          ST_IDLE, ST_HALTED: begin
            if (start) begin
              state_r       <= ST_ARMED;
              history_r     <= {PAT_W{1'b0}};
              fill_r        <= {LEN_W{1'b0}};
              match_count_r <= {CNT_W{1'b0}};
            end
          end
          ST_ARMED: begin
            if (i_valid) begin
              history_r <= hist_next_s;
              if (hit_s) begin
                out_r         <= 1'b1;
                match_count_r <= cnt_inc_s;
                fill_r        <= overlap_r ? fill_sat_s : {LEN_W{1'b0}};
                if ((thresh_r != {CNT_W{1'b0}}) && (cnt_inc_s == thresh_r)) begin
                  state_r <= ST_HALTED;
                end
              end else begin
                fill_r <= fill_sat_s;
              end
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign out         = out_r;
  assign match_count = match_count_r;
  assign busy        = (state_r == ST_ARMED);
  assign done        = (state_r == ST_HALTED);
  assign cfg_ready   = (state_r == ST_IDLE);

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: stimulus queues expected match pulses,
// a negedge monitor pops and checks them against the DUT's out/match_count.
module tb_seq_detect_ctrl;

  logic       clock;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [4:0] cfg_pattern;
  logic [2:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_thresh;
  logic       start;
  logic       stop;
  logic       i_valid;
  logic       i;
  logic       out;
  logic [7:0] match_count;
  logic       busy;
  logic       done;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   cyc;
  int   errors;
  int   checks;

  seq_detect_ctrl #(.PAT_W(5), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh),
    .start(start), .stop(stop),
    .i_valid(i_valid), .i(i),
    .out(out), .match_count(match_count),
    .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every out pulse must match the head of the expectation queue.
  always @(negedge clock) begin
    if (out === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got out=1 at cycle %0d expected no pulse", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.cyc != cyc || match_count !== e.cnt) begin
          errors++;
          $display("FAIL pulse: got cycle %0d count %0d expected cycle %0d count %0d",
                   cyc, match_count, e.cyc, e.cnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_cfg(input logic [4:0] p, input logic [2:0] l, input logic ov, input logic [7:0] th);
    cfg_valid = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = ov; cfg_thresh = th;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic exp_hit, input logic [7:0] exp_cnt);
    exp_t e;
    i_valid = 1'b1;
    i = b;
    if (exp_hit) begin
      e.cyc = cyc + 1;
      e.cnt = exp_cnt;
      sb_q.push_back(e);
    end
    tick();
    i_valid = 1'b0;
  endtask

  // Bounded wait for outstanding pulses; leftovers count as a failure.
  task automatic drain(input string name);
    repeat (3) tick();
    chk(name, sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1;
    cfg_valid = 1'b0; cfg_pattern = 5'd0; cfg_len = 3'd0; cfg_overlap = 1'b0; cfg_thresh = 8'd0;
    start = 1'b0; stop = 1'b0; i_valid = 1'b0; i = 1'b0;
    #2;
    chk("rst_out", out, 0);
    chk("rst_count", match_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    tick();
    reset = 1'b0;
    tick();

    // Overlapping 1101 detection: pulses after bits 4 and 7.
    do_cfg(5'b01101, 3'd4, 1'b1, 8'd0);
    do_start();
    chk("armed_busy", busy, 1);
    send_bit(1'b1, 1'b0, 8'd0);
    send_bit(1'b1, 1'b0, 8'd0);
    send_bit(1'b0, 1'b0, 8'd0);
    send_bit(1'b1, 1'b1, 8'd1);
    send_bit(1'b1, 1'b0, 8'd0);
    send_bit(1'b0, 1'b0, 8'd0);
    send_bit(1'b1, 1'b1, 8'd2);
    drain("ovl_drain");
    chk("ovl_count", match_count, 2);
    do_stop();
    chk("stop_hold_count", match_count, 2);
    chk("stop_idle", cfg_ready, 1);

    // Same stream, non-overlapping: only one pulse.
    do_cfg(5'b01101, 3'd4, 1'b0, 8'd0);
    do_start();
    chk("start_clears_count", match_count, 0);
    send_bit(1'b1, 1'b0, 8'd0);
    send_bit(1'b1, 1'b0, 8'd0);
    send_bit(1'b0, 1'b0, 8'd0);
    send_bit(1'b1, 1'b1, 8'd1);
    send_bit(1'b1, 1'b0, 8'd0);
    send_bit(1'b0, 1'b0, 8'd0);
    send_bit(1'b1, 1'b0, 8'd0);
    drain("novl_drain");
    chk("novl_count", match_count, 1);
    do_stop();

    // Threshold halt after three matches of "11"; fifth bit ignored.
    do_cfg(5'b00011, 3'd2, 1'b1, 8'd3);
    do_start();
    send_bit(1'b1, 1'b0, 8'd0);
    send_bit(1'b1, 1'b1, 8'd1);
    send_bit(1'b1, 1'b1, 8'd2);
    send_bit(1'b1, 1'b1, 8'd3);
    chk("thr_done", done, 1);
    chk("thr_busy", busy, 0);
    send_bit(1'b1, 1'b0, 8'd0);
    drain("thr_drain");
    chk("thr_count", match_count, 3);
    chk("halt_cfg_ready", cfg_ready, 0);

    // Restart from HALTED, config write ignored while armed, stop beats a match.
    do_start();
    chk("rearm_busy", busy, 1);
    chk("rearm_count", match_count, 0);
    chk("armed_cfg_ready", cfg_ready, 0);
    do_cfg(5'b00000, 3'd2, 1'b0, 8'd0);
    send_bit(1'b1, 1'b0, 8'd0);
    send_bit(1'b1, 1'b1, 8'd1);
    i_valid = 1'b1; i = 1'b1; stop = 1'b1;
    tick();
    i_valid = 1'b0; stop = 1'b0;
    drain("stop_drain");
    chk("stop_busy", busy, 0);
    chk("stop_ready", cfg_ready, 1);
    chk("stop_count", match_count, 1);

    // cfg_len=0 behaves as single-bit match on pattern[0].
    do_cfg(5'b00001, 3'd0, 1'b0, 8'd0);
    do_start();
    send_bit(1'b1, 1'b1, 8'd1);
    send_bit(1'b0, 1'b0, 8'd0);
    send_bit(1'b1, 1'b1, 8'd2);
    drain("len0_drain");
    chk("len0_count", match_count, 2);
    do_stop();

    // cfg_len=7 clamps to 5; idle gaps do not break the match.
    do_cfg(5'b10110, 3'd7, 1'b0, 8'd0);
    do_start();
    send_bit(1'b1, 1'b0, 8'd0);
    send_bit(1'b0, 1'b0, 8'd0);
    tick();
    send_bit(1'b1, 1'b0, 8'd0);
    send_bit(1'b1, 1'b0, 8'd0);
    repeat (2) tick();
    send_bit(1'b0, 1'b1, 8'd1);
    drain("len7_drain");
    chk("len7_count", match_count, 1);

    // Async reset mid-ARMED clears out and busy without a clock edge, and the config.
    do_stop();
    do_cfg(5'b00001, 3'd1, 1'b0, 8'd0);
    do_start();
    i_valid = 1'b1; i = 1'b1;
    tick();
    i_valid = 1'b0;
    chk("pre_reset_out", out, 1);
    reset = 1'b1;
    #1;
    chk("async_out", out, 0);
    chk("async_busy", busy, 0);
    chk("async_count", match_count, 0);
    chk("async_ready", cfg_ready, 1);
    tick();
    reset = 1'b0;
    tick();
    do_start();
    send_bit(1'b0, 1'b1, 8'd1);
    drain("post_reset_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
